// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, sync polarities,
// the 12-bit {R,G,B} field split and the bundle carried through the delay line.
package vga_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  localparam int RGB_W = 12;

  typedef struct packed {
    logic hs;
    logic vs;
    logic bright;
  } sync_t;

  function automatic logic [3:0] rgb_red(input logic [RGB_W-1:0] rgb);
    return rgb[11:8];
  endfunction

  function automatic logic [3:0] rgb_green(input logic [RGB_W-1:0] rgb);
    return rgb[7:4];
  endfunction

  function automatic logic [3:0] rgb_blue(input logic [RGB_W-1:0] rgb);
    return rgb[3:0];
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register with synchronous clear.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int W     = 3,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         ce_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout_o = din_i;
    end else begin : g_pipe
      logic [W-1:0] stage_q [DEPTH];

      // shift one stage per enable, clear every stage on reset
      always_ff @(posedge clk_i) begin
        if (srst_i) begin
          for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (ce_i) begin
          stage_q[0] <= din_i;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout_o = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel clock-enable, h/v counters,
// line/frame strobes, frame counter, and PIPE-aligned sync/colour outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV   = DEF_CLK_DIV,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic HS_POL    = SYNC_ACTIVE_LOW,
  parameter logic VS_POL    = SYNC_ACTIVE_LOW,
  parameter int   PIPE      = 2,
  parameter int   CW        = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [11:0]   rgb_in,
  output logic [CW-1:0] hCount,
  output logic [CW-1:0] vCount,
  output logic          bright,
  output logic          pix_ce,
  output logic          line_tick,
  output logic          frame_tick,
  output logic [15:0]   frame_count,
  output logic          hSync,
  output logic          vSync,
  output logic [3:0]    vgaR,
  output logic [3:0]    vgaG,
  output logic [3:0]    vgaB
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [15:0]   frame_q, frame_d;
  logic          pix_ce_s, h_last_s, v_last_s;
  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;
  sync_t         raw_s, dly_s;

  // divider, counter next-state and strobes from registered state
  always_comb begin
    pix_ce_s = (div_q == DIV_LAST);
    h_last_s = (h_q == H_LAST);
    v_last_s = (v_q == V_LAST);
    div_d    = div_q;
    h_d      = h_q;
    v_d      = v_q;
    frame_d  = frame_q;
    if (pix_ce_s) begin
      div_d = '0;
      if (h_last_s) begin
        h_d = '0;
        if (v_last_s) begin
          v_d     = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end else begin
      div_d = div_q + DW'(1);
    end
  end

  // timing state registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  assign raw_s.hs     = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign raw_s.vs     = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
  assign raw_s.bright = (h_q < H_VIS_C) && (v_q < V_VIS_C);

  vga_delay_line #(
    .W     ($bits(sync_t)),
    .DEPTH (PIPE)
  ) u_delay (
    .clk_i  (Clk),
    .srst_i (Reset),
    .ce_i   (pix_ce_s),
    .din_i  (raw_s),
    .dout_o (dly_s)
  );

  // final output register: pin polarity and blanking applied here
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      rgb_q <= 12'h000;
    end else if (pix_ce_s) begin
      hs_q  <= dly_s.hs ? HS_POL : ~HS_POL;
      vs_q  <= dly_s.vs ? VS_POL : ~VS_POL;
      rgb_q <= dly_s.bright ? rgb_in : 12'h000;
    end
  end

  assign hCount      = h_q;
  assign vCount      = v_q;
  assign bright      = raw_s.bright;
  assign pix_ce      = pix_ce_s;
  assign line_tick   = pix_ce_s && h_last_s;
  assign frame_tick  = pix_ce_s && h_last_s && v_last_s;
  assign frame_count = frame_q;
  assign hSync       = hs_q;
  assign vSync       = vs_q;
  assign vgaR        = rgb_red(rgb_q);
  assign vgaG        = rgb_green(rgb_q);
  assign vgaB        = rgb_blue(rgb_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a shrunken 30x15 raster so whole
// frames fit in a short run; a second CLK_DIV=1 / HS_POL=1 instance rides along.
module tb_vga_timing_gen;

  // 16+4+6+4 = 30 pixels per line, 8+2+2+3 = 15 lines per frame
  logic        clk = 1'b0;
  logic        rst;
  logic        rgb_mode;
  logic [11:0] rgb_const;
  logic [11:0] rgb_s;

  logic [9:0]  a_hc, a_vc, b_hc, b_vc;
  logic        a_bright, a_ce, a_lt, a_ft, a_hs, a_vs;
  logic        b_bright, b_ce, b_lt, b_ft, b_hs, b_vs;
  logic [15:0] a_fc, b_fc;
  logic [3:0]  a_r, a_g, a_b, b_r, b_g, b_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rgb_s = rgb_mode ? ((a_hc == 10'd12) ? 12'hF00 : 12'h000) : rgb_const;

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(2), .CW(10)
  ) u_dut (
    .Clk(clk), .Reset(rst), .rgb_in(rgb_s),
    .hCount(a_hc), .vCount(a_vc), .bright(a_bright), .pix_ce(a_ce),
    .line_tick(a_lt), .frame_tick(a_ft), .frame_count(a_fc),
    .hSync(a_hs), .vSync(a_vs), .vgaR(a_r), .vgaG(a_g), .vgaB(a_b)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
    .V_VISIBLE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .PIPE(2), .CW(10)
  ) u_dut1 (
    .Clk(clk), .Reset(rst), .rgb_in(rgb_s),
    .hCount(b_hc), .vCount(b_vc), .bright(b_bright), .pix_ce(b_ce),
    .line_tick(b_lt), .frame_tick(b_ft), .frame_count(b_fc),
    .hSync(b_hs), .vSync(b_vs), .vgaR(b_r), .vgaG(b_g), .vgaB(b_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // after each edge, the sampled state is what the next edge will see
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    int lt0 = -1, lt1 = -1, ft_n = 0, ft_last = -1, blue_cnt = 0;
    int b_ce_zero = 0, b_rise = -1, b_fall = -1, b_hi = 0;
    int red_cnt = 0, red_at13 = 0, gb_cnt = 0, vs2_fall = -1;
    logic found;

    rst = 1'b1; rgb_mode = 1'b0; rgb_const = 12'hFFF;
    repeat (3) step();

    chk("rst_hcount", a_hc, 0);
    chk("rst_vcount", a_vc, 0);
    chk("rst_frame_count", a_fc, 0);
    chk("rst_bright", a_bright, 1);
    chk("rst_pix_ce", a_ce, 0);
    chk("rst_line_tick", a_lt, 0);
    chk("rst_frame_tick", a_ft, 0);
    chk("rst_hsync", a_hs, 1);
    chk("rst_vsync", a_vs, 1);
    chk("rst_rgb", {a_r, a_g, a_b}, 0);
    chk("rst_b_hsync", b_hs, 0);
    chk("rst_b_pix_ce", b_ce, 1);

    rst = 1'b0;
    for (int k = 0; k < 5460; k++) begin
      if (!a_hs && hs_fall < 0) hs_fall = k;
      if (hs_fall >= 0 && hs_rise < 0 && a_hs) hs_rise = k;
      if (!a_vs && vs_fall < 0) vs_fall = k;
      if (vs_fall >= 0 && vs_rise < 0 && a_vs) vs_rise = k;
      if (a_lt) begin
        if (lt0 < 0) lt0 = k;
        else if (lt1 < 0) lt1 = k;
      end
      if (a_ft) begin
        ft_n++;
        ft_last = k;
      end
      if (k >= 12 && k < 1812 && a_b == 4'hF) blue_cnt++;
      if (k == 60) chk("bright_h15", a_bright, 1);
      if (k == 64) chk("bright_h16", a_bright, 0);
      if (k == 1800) chk("frame_count_1", a_fc, 1);
      if (k == 5400) chk("frame_count_3", a_fc, 3);
      if (!b_ce) b_ce_zero++;
      if (b_hs && b_rise < 0) b_rise = k;
      if (b_rise >= 0 && b_fall < 0 && !b_hs) b_fall = k;
      if (k >= 30 && k < 60 && b_hs) b_hi++;
      step();
    end

    chk("hsync_fall", hs_fall, 92);
    chk("hsync_rise", hs_rise, 116);
    chk("vsync_fall", vs_fall, 1212);
    chk("vsync_rise", vs_rise, 1452);
    chk("line_tick_0", lt0, 119);
    chk("line_tick_1", lt1, 239);
    chk("frame_tick_n", ft_n, 3);
    chk("frame_tick_last", ft_last, 5399);
    chk("blue_visible_clocks", blue_cnt, 512);
    chk("b_pix_ce_low", b_ce_zero, 0);
    chk("b_hsync_rise", b_rise, 23);
    chk("b_hsync_fall", b_fall, 29);
    chk("b_hsync_high_per_line", b_hi, 6);

    // one red pixel fed PIPE ticks late must land at hCount 13
    rgb_mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (a_vc == 10'd2 && a_hc == 10'd0) found = 1'b1;
      else step();
    end
    chk("wait_line2", found, 1);
    for (int i = 0; i < 120; i++) begin
      if (a_r == 4'hF) red_cnt++;
      if (a_r == 4'hF && a_hc == 10'd13) red_at13++;
      if (a_g != 4'h0 || a_b != 4'h0) gb_cnt++;
      step();
    end
    chk("red_clocks", red_cnt, 4);
    chk("red_at_h13", red_at13, 4);
    chk("green_blue_zero", gb_cnt, 0);

    // reset in the middle of vertical sync
    rgb_mode = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (a_vc == 10'd10 && a_hc == 10'd5) found = 1'b1;
      else step();
    end
    chk("wait_line10", found, 1);
    chk("vsync_before_reset", a_vs, 0);
    rst = 1'b1;
    step();
    chk("mid_rst_vsync", a_vs, 1);
    chk("mid_rst_hsync", a_hs, 1);
    chk("mid_rst_hcount", a_hc, 0);
    chk("mid_rst_vcount", a_vc, 0);
    chk("mid_rst_frame_count", a_fc, 0);
    chk("mid_rst_rgb", {a_r, a_g, a_b}, 0);
    chk("mid_rst_pix_ce", a_ce, 0);
    rst = 1'b0;
    for (int k = 0; k < 1500 && vs2_fall < 0; k++) begin
      if (!a_vs) vs2_fall = k;
      else step();
    end
    chk("vsync_fall_after_reset", vs2_fall, 1212);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 display controller feeding the VGA pins on the Nexys4 top. It derives a pixel clock-enable from the board clock and generates horizontal/vertical counters, blanking and sync. It also delays sync and colour through a configurable pipeline, so pixel logic with multi-cycle latency (sprite lookup, score overlay) stays aligned with the sync pulses. It adds line/frame strobes and a frame counter for game-physics timing. It sits between the pixel-colour logic and the `hSync`/`vSync`/`vgaR`/`vgaG`/`vgaB` pins.

## Interface
Parameters:
- `CLK_DIV`, 4: board clocks per pixel; must be ≥1.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 0: active level of `hSync`.
- `VS_POL`, 0: active level of `vSync`.
- `PIPE`, 2: pixel-logic latency in pixel ticks, 0..8.
- `CW`, 10: counter width; must hold H_TOTAL−1 and V_TOTAL−1.

Ports:
- `Clk` in 1: board clock, 100 MHz.
- `Reset` in 1: synchronous, active-high reset.
- `rgb_in` in 12: pixel colour {R,G,B}, valid PIPE ticks after the matching `hCount`/`vCount`.
- `hCount` out CW: current pixel column, undelayed.
- `vCount` out CW: current line, undelayed.
- `bright` out 1: undelayed visible-area flag.
- `pix_ce` out 1: one-Clk pixel strobe.
- `line_tick` out 1: one-Clk pulse on the last pixel of each line.
- `frame_tick` out 1: one-Clk pulse on the last pixel of each frame.
- `frame_count` out 16: frames completed since reset; wraps.
- `hSync` out 1: horizontal sync, delayed PIPE ticks.
- `vSync` out 1: vertical sync, delayed PIPE ticks.
- `vgaR` out 4: red, delayed PIPE ticks.
- `vgaG` out 4: green, delayed PIPE ticks.
- `vgaB` out 4: blue, delayed PIPE ticks.

## Operation
- Derived totals: H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP; V_TOTAL is the same sum over the vertical parameters.
- Divider counts 0..CLK_DIV−1. `pix_ce` is high in the Clk cycle where divider = CLK_DIV−1. With CLK_DIV=1, `pix_ce` is constantly 1.
- On `pix_ce`:
  - `hCount` increments, wrapping H_TOTAL−1→0.
  - On that wrap, `vCount` increments, wrapping V_TOTAL−1→0.
  - On the vertical wrap, `frame_count` increments modulo 2^16.
- `bright` = (`hCount` < H_VISIBLE) && (`vCount` < V_VISIBLE).
- Raw horizontal sync is active for `hCount` in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC−1]. Raw vertical sync uses the same rule on `vCount`.
- Delay line: PIPE stages, each advancing only on `pix_ce`, carrying {raw hs, raw vs, `bright`}.
- Colour outputs: delayed `bright` ? `rgb_in` : 0, registered on `pix_ce`. PIPE=0 means sync and `rgb_in` pass through with only the final output register.
- Output pins drive the active level when sync is active, else the inactive level (!POL).
- `line_tick` = `pix_ce` && `hCount`==H_TOTAL−1.
- `frame_tick` = `line_tick` && `vCount`==V_TOTAL−1.
- Reset mid-frame: divider, counters, `frame_count` and every delay stage clear on the next edge. Sync pins go inactive, colour goes to 0, strobes go to 0. No partial sync pulse survives reset.

## Timing
- Clock 0 is the first Clk edge with `Reset` low.
- `hCount`=N, `vCount`=0 is presented during clocks CLK_DIV·N .. CLK_DIV·N+CLK_DIV−1 of the first line.
- Sync and colour pins show the pixel-N state during clocks CLK_DIV·(N+PIPE+1) onward. That is PIPE+1 ticks of latency, including the output register.
- Strobes (`pix_ce`, `line_tick`, `frame_tick`) are combinational from registered state and last exactly one Clk cycle.
- Reset values:
  - `hCount`, `vCount`, `frame_count`: 0.
  - `bright`: 1, since (0,0) is visible.
  - `pix_ce`, `line_tick`, `frame_tick`: 0.
  - `hSync`/`vSync`: inactive level.
  - `vgaR`/`vgaG`/`vgaB`: 0.

## Structure
- Shared package `vga_pkg`:
  - Default 640x480@60 timing constants.
  - Sync-polarity constants.
  - The `rgb` 12-bit field split (11:8 R, 7:4 G, 3:0 B).
- One sub-module, `vga_delay_line`: parametrised width and depth, ce-gated shift register with synchronous clear. Instantiated once for sync/bright.

## Test plan
- Reset release with defaults:
  - `hSync` goes low at clock 4·(656+3) = 2636.
  - It returns high 96·4 = 384 clocks later.
  - `vgaR/G/B` are 0 throughout reset.
- Line and frame periods:
  - `line_tick` pulses every 3200 clocks.
  - `frame_tick` pulses every 3200·525 = 1,680,000 clocks.
  - `frame_count` reads 3 after the third pulse.
- Blanking: `rgb_in`=12'hFFF held constant. Colour is FFF only while delayed `bright` is high; 0 during porches and sync.
- PIPE alignment: drive `rgb_in`=12'hF00 only when `hCount`==10 (shifted by PIPE=2 ticks). Red appears for exactly one pixel, 4 clocks, at `hCount`=13 time.
- Mid-frame reset:
  - Assert `Reset` at `vCount`=490, inside vsync.
  - Next edge: `vSync` goes inactive, counters and `frame_count` go to 0.
  - The first vsync after release occurs at line 490 of the new frame.
- CLK_DIV=1, HS_POL=1 build:
  - `pix_ce` is constant 1.
  - `hSync` is high for 96 consecutive clocks per 800.
